// File: rtl/aes_key_expand_pkg.sv
// Shared AES-128 key-schedule definitions: round count, Rcon table, round-key
// array type and the expander FSM states.
package aes_key_expand_pkg;

   localparam int unsigned NR = 10;

   typedef logic [NR:0][127:0] round_keys_t;

   // Round constants for rounds 1..10, each the top byte of its Rcon word.
   localparam logic [10:1][7:0] RCON = {
      8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
      8'h10, 8'h08, 8'h04, 8'h02, 8'h01
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_DONE
   } state_e;

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-load handshake and round-key bus between the key source, the expander
// and the AES round pipeline.
interface aes_key_expand_if;
   import aes_key_expand_pkg::*;

   logic          valid_i;
   logic [127:0]  key_i;
   logic          ready_o;
   logic          key_valid_o;
   round_keys_t   round_key_o;

   modport master (
      output valid_i,
      output key_i,
      input  ready_o,
      input  key_valid_o,
      input  round_key_o
   );

   modport slave (
      input  valid_i,
      input  key_i,
      output ready_o,
      output key_valid_o,
      output round_key_o
   );

endinterface

// File: rtl/aes_key_expand_round.sv
// One AES-128 key-schedule step: next round key from the previous round key
// and that round's Rcon byte.
module aes_key_round (
   input  logic [127:0] prev_key_i,
   input  logic [7:0]   rcon_i,
   output logic [127:0] next_key_o
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot_w, sub_w, t_w;
   logic [31:0] n0, n1, n2, n3;

   assign w0 = prev_key_i[127:96];
   assign w1 = prev_key_i[95:64];
   assign w2 = prev_key_i[63:32];
   assign w3 = prev_key_i[31:0];

   // RotWord: the most significant byte of w3 wraps to the bottom.
   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sub
      s_box u_sbox (
         .in_i  (rot_w[8*i +: 8]),
         .out_o (sub_w[8*i +: 8])
      );
   end

   assign t_w = sub_w ^ {rcon_i, 24'h000000};
   assign n0  = w0 ^ t_w;
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;

   assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/s_box.sv
// AES forward S-box as a combinational lookup table.
module s_box (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key expander: accepts a cipher key, produces one round key
// per clock and holds all eleven keys on the round-key bus.
module aes_key_expand
   import aes_key_expand_pkg::*;
(
   input logic             clk,
   input logic             rst_n,
   aes_key_expand_if.slave kif
);

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   round_keys_t  keys_q, keys_d;
   logic         kv_q, kv_d;

   logic [127:0] prev_key;
   logic [7:0]   rcon;
   logic [127:0] next_key;

   // Counter k selects key k-1 as the source for round k.
   always_comb begin
      prev_key = '0;
      rcon     = '0;
      for (int unsigned k = 1; k <= NR; k++) begin
         if (cnt_q == 4'(k)) begin
            prev_key = keys_q[4'(k - 1)];
            rcon     = RCON[4'(k)];
         end
      end
   end

   aes_key_round u_round (
      .prev_key_i (prev_key),
      .rcon_i     (rcon),
      .next_key_o (next_key)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      keys_d  = keys_q;
      kv_d    = kv_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (kif.valid_i) begin
               keys_d[0] = kif.key_i;
               cnt_d     = 4'd1;
               kv_d      = 1'b0;
               state_d   = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            if (cnt_q == '0 || cnt_q > 4'(NR)) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd1;
            end else begin
               for (int unsigned k = 1; k <= NR; k++) begin
                  if (cnt_q == 4'(k)) keys_d[4'(k)] = next_key;
               end
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'(NR)) begin
                  state_d = ST_DONE;
                  kv_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd1;
         keys_q  <= '0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         keys_q  <= keys_d;
         kv_q    <= kv_d;
      end
   end

   assign kif.ready_o     = (state_q != ST_EXPAND);
   assign kif.key_valid_o = kv_q;
   assign kif.round_key_o = keys_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: word-level FIPS-197 key-schedule model
// with an algebraically derived S-box, plus a behavioural AES encryptor.
module tb_aes_key_expand;
   import aes_key_expand_pkg::*;

   localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] A1_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A1_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] C1_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] PT       = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT       = 128'h3925841d02dc09fbdc118597196a0b32;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   aes_key_expand_if kif();

   aes_key_expand dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kif   (kif)
   );

   typedef struct packed {
      round_keys_t keys;
      logic [31:0] acc_edge;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad   = 0;
   int unsigned edge_cnt   = 0;
   int unsigned busy_until = 0;
   round_keys_t last_exp   = '0;
   logic [7:0]  sbox_m [256];
   logic        prev_kv  = 1'b0;
   logic        accepted = 1'b0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = '0; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_m[w[8*i +: 8]];
      return r;
   endfunction

   function automatic round_keys_t model_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      round_keys_t rk;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[4'(r)] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return rk;
   endfunction

   function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input round_keys_t rk);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [127:0] s;
      s = pt ^ rk[0];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) b[i] = sbox_m[s[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*c] = b[w + 4*((c+w)%4)];
         for (int c = 0; c < 4; c++) begin
            if (r != 10) begin
               b[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
               b[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
               b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
               b[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
            end else begin
               for (int w = 0; w < 4; w++) b[4*c+w] = t[4*c+w];
            end
         end
         for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
         s = s ^ rk[4'(r)];
      end
      return s;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Drive one cycle's inputs; the busy window of the bench's own model decides acceptance.
   task automatic drive(input logic v, input logic [127:0] k);
      logic mr;
      @(negedge clk);
      kif.valid_i = v;
      kif.key_i   = k;
      #1;
      mr = (edge_cnt >= busy_until);
      check("ready_o", 128'(kif.ready_o), 128'(mr));
      accepted = 1'b0;
      if (v && mr) begin
         sb_q.push_back('{keys: model_expand(k), acc_edge: edge_cnt + 1});
         busy_until = edge_cnt + 1 + NR;
         accepted   = 1'b1;
      end
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < max_cyc) begin
         drive(1'b0, rand128());
         n++;
      end
      check("drain_timeout", 128'(sb_q.size()), 128'(0));
   endtask

   task automatic check_outputs(input string tag, input round_keys_t req, input logic kv_req);
      for (int i = 0; i <= 10; i++)
         check($sformatf("%s_rk%0d", tag, i), kif.round_key_o[4'(i)], req[4'(i)]);
      check($sformatf("%s_kv", tag), 128'(kif.key_valid_o), 128'(kv_req));
   endtask

   // Monitor: every rising key_valid_o retires one scoreboard entry.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            prev_kv = 1'b0;
         end else begin
            if (kif.key_valid_o && !prev_kv) begin
               if (sb_q.size() == 0) begin
                  check("kv_rise_unexpected", 128'(kif.key_valid_o), 128'(0));
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  check("latency", 128'(edge_cnt - e.acc_edge), 128'(NR));
                  for (int i = 0; i <= 10; i++)
                     check($sformatf("sched_rk%0d", i), kif.round_key_o[4'(i)], e.keys[4'(i)]);
                  last_exp = e.keys;
               end
            end
            prev_kv = kif.key_valid_o;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] ka, kb;
      logic         got;
      kif.valid_i = 1'b0;
      kif.key_i   = '0;

      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end

      #1 rst_n = 1'b0;
      #1;
      check("rst_ready", 128'(kif.ready_o), 128'(1));
      check_outputs("rst", '0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // FIPS-197 A.1 and the integration encryption.
      drive(1'b1, KEY_A1);
      wait_idle(20);
      check("a1_rk1", kif.round_key_o[1], A1_RK1);
      check("a1_rk10", kif.round_key_o[10], A1_RK10);
      check("cipher", aes_encrypt(PT, kif.round_key_o), CT);

      repeat (50) begin
         drive(1'b0, rand128());
         check_outputs("hold", last_exp, 1'b1);
      end

      // Busy rejection: key B offered for nine cycles while A expands.
      ka = rand128();
      kb = rand128();
      drive(1'b1, ka);
      repeat (9) drive(1'b1, kb);
      wait_idle(20);
      check_outputs("busy", model_expand(ka), 1'b1);

      // Back-to-back: valid held high, key switched while busy.
      drive(1'b1, KEY_C1);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         drive(1'b1, KEY_A1);
         got = accepted;
      end
      check("b2b_c1_rk10", kif.round_key_o[10], C1_RK10);
      check("b2b_kv_before", 128'(kif.key_valid_o), 128'(1));
      drive(1'b0, rand128());
      check("b2b_kv_drop", 128'(kif.key_valid_o), 128'(0));
      wait_idle(20);
      check("b2b_a1_rk10", kif.round_key_o[10], A1_RK10);

      for (int t = 0; t < 6; t++) begin
         drive(1'b1, rand128());
         wait_idle(20);
         repeat ($urandom_range(0, 3)) drive(1'b0, rand128());
      end

      // Asynchronous reset part-way through an expansion.
      drive(1'b1, rand128());
      repeat (4) drive(1'b0, rand128());
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_ready", 128'(kif.ready_o), 128'(1));
      check_outputs("midrst", '0, 1'b0);
      sb_q.delete();
      busy_until = 0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, KEY_A1);
      wait_idle(20);
      check("post_rst_rk10", kif.round_key_o[10], A1_RK10);

      repeat (3) drive(1'b0, rand128());
      check("final_queue", 128'(sb_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
